stream_burst_arbiter: RTL and testbench

Shares one valid/ready 8-bit data source, such as the `counter_8bit` sequence generator, among `NUM_PORTS` consumers. Each requesting consumer is granted a burst of exactly `BURST_LEN` beats. Grants are issued round-robin, and each grant is held until its burst completes. The block sits between the source and the consumers and is the only path from the source to any consumer.

---
 rtl/stream_burst_arbiter.sv | 138 +++++++++++++
 tb/tb_stream_burst_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_burst_arbiter.sv
// stream_burst_arbiter
//   Shares one valid/ready source among NUM_PORTS consumers. Each requester
//   gets a committed burst of exactly BURST_LEN beats, and grants rotate in
//   round-robin order.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready source handshake (in_ready combinational from grant)
//   in_data           source data
//   req[NUM_PORTS]    level-sensitive burst requests
//   out_valid[N]      per-consumer valid (only the granted bit can be set)
//   out_ready[N]      per-consumer ready
//   out_data          shared data bus, a straight copy of in_data
//   grant[N]          registered one-hot grant, zero when idle
//   burst_done        registered pulse in the cycle after a burst's last beat
module stream_burst_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]  req,
  output logic [NUM_PORTS-1:0]  out_valid,
  input  logic [NUM_PORTS-1:0]  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]  grant,
  output logic                  burst_done
);

  localparam int unsigned PORT_W = $clog2(NUM_PORTS);
  localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [PORT_W-1:0]    PORT_LAST = PORT_W'(NUM_PORTS - 1);
  localparam logic [NUM_PORTS-1:0] ONE_HOT0  = NUM_PORTS'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PORT_W-1:0]    last_q, last_d;
  logic                 done_q, done_d;

  logic                 beat;
  logic                 final_beat;
  logic                 arb_point;
  logic                 found;
  logic [PORT_W-1:0]    pick;
  logic [PORT_W-1:0]    scan_idx;

  assign grant      = grant_q;
  assign burst_done = done_q;
  assign out_data   = in_data;

  // Datapath steering; forced quiet while reset is held so a burst that was
  // in flight cannot move a beat during the reset cycle itself.
  always_comb begin
    out_valid = '0;
    in_ready  = 1'b0;
    if (!reset && state_q == BURST) begin
      out_valid = grant_q & {NUM_PORTS{in_valid}};
      in_ready  = |(grant_q & out_ready);
    end
  end

  assign beat       = in_valid && in_ready;
  assign final_beat = beat && (cnt_q == CNT_LAST);
  assign arb_point  = (state_q == IDLE) || final_beat;

  // Round-robin scan starting just after the last granted port; the last
  // granted port itself is visited last, giving it lowest priority.
  always_comb begin
    found    = 1'b0;
    pick     = last_q;
    scan_idx = last_q;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      scan_idx = PORT_W'((32'(last_q) + i) % NUM_PORTS);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // Next-state: count beats inside a burst, re-arbitrate at the final beat
  // (no bubble) or on every idle cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = 1'b0;

    if (state_q == BURST && beat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (final_beat) begin
      done_d = 1'b1;
    end

    if (arb_point) begin
      cnt_d = '0;
      if (found) begin
        state_d = BURST;
        grant_d = ONE_HOT0 << pick;
        last_d  = pick;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  // State register; reset aborts any burst and restores port 0 priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      last_q  <= PORT_LAST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_stream_burst_arbiter.sv
// Testbench for stream_burst_arbiter: scoreboard of expected beats
// (port, data, last-of-burst) checked by a monitor on every handshake,
// plus a BURST_LEN=1 instance exercised with directed per-cycle checks.
module tb_stream_burst_arbiter;

  logic       clock;
  logic       reset;

  // main instance: 4 ports, 4-beat bursts
  logic       in_valid;
  logic       in_ready;
  logic [7:0] src;
  logic [3:0] req;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [3:0] grant;
  logic       burst_done;

  // single-beat instance
  logic       in_valid1;
  logic       in_ready1;
  logic [7:0] src1;
  logic [3:0] req1;
  logic [3:0] out_valid1;
  logic [3:0] out_ready1;
  logic [7:0] out_data1;
  logic [3:0] grant1;
  logic       burst_done1;

  typedef struct {
    int         port;
    logic [7:0] data;
    bit         last;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  bit    exp_done = 1'b0;

  stream_burst_arbiter #(.NUM_PORTS(4), .BURST_LEN(4), .DATA_WIDTH(8)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(src),
    .req(req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .grant(grant), .burst_done(burst_done)
  );

  stream_burst_arbiter #(.NUM_PORTS(4), .BURST_LEN(1), .DATA_WIDTH(8)) u_dut1 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(src1),
    .req(req1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .grant(grant1), .burst_done(burst_done1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Sources: counting sequence that advances on each accepted beat.
  always @(posedge clock) begin
    if (reset) src <= 8'h00;
    else if (in_valid && in_ready) src <= src + 8'h01;
  end
  always @(posedge clock) begin
    if (reset) src1 <= 8'h00;
    else if (in_valid1 && in_ready1) src1 <= src1 + 8'h01;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int port, input logic [7:0] data, input bit last);
    beat_t e;
    e.port = port;
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Called at #1 after a rising edge; returns at the same phase.
  task automatic wait_q(input int target, input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() > target && cycles < budget) begin
      @(posedge clock); #1;
      cycles++;
    end
    chk("wait_queue_drain", 32'(exp_q.size() <= target), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    req       = 4'b0000;
    req1      = 4'b0000;
    out_ready = 4'b1111;
    out_ready1 = 4'b1111;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Monitor: every handshake must match the head of the scoreboard, and
  // burst_done must follow exactly the beats flagged as last-of-burst.
  always @(negedge clock) begin
    if (reset) begin
      exp_done = 1'b0;
    end else begin
      chk("burst_done", 32'(burst_done), 32'(exp_done));
      exp_done = 1'b0;
      if (in_valid && in_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          beat_t e;
          logic [3:0] oh;
          e  = exp_q.pop_front();
          oh = 4'b0001 << e.port;
          chk("beat_grant", 32'(grant), 32'(oh));
          chk("beat_out_valid", 32'(out_valid), 32'(oh));
          chk("beat_data", 32'(out_data), 32'(e.data));
          exp_done = e.last;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_valid1  = 1'b0;
    req        = 4'b0000;
    req1       = 4'b0000;
    out_ready  = 4'b1111;
    out_ready1 = 4'b1111;
    do_reset();

    // Reset state
    @(negedge clock);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    @(posedge clock); #1;

    // 1: single requester, two back-to-back bursts on port 0
    for (int k = 0; k < 8; k++) push(0, 8'(k), (k % 4) == 3);
    req      = 4'b0001;
    in_valid = 1'b1;
    @(negedge clock);
    chk("t1_grant_before", 32'(grant), 32'h0);
    chk("t1_idle_in_ready", 32'(in_ready), 32'h0);
    @(negedge clock);
    chk("t1_grant_after", 32'(grant), 32'h1);
    @(posedge clock); #1;
    wait_q(0, 50, cyc);
    chk("t1_beat_cycles", 32'(cyc + 1), 32'd8);
    in_valid = 1'b0;
    req      = 4'b0000;
    do_reset();

    // 2: all ports requesting, grants 0,1,2,3,0
    for (int k = 0; k < 20; k++) push((k / 4) % 4, 8'(k), (k % 4) == 3);
    req      = 4'b1111;
    in_valid = 1'b1;
    wait_q(0, 100, cyc);
    in_valid = 1'b0;
    req      = 4'b0000;
    do_reset();

    // 3: random stalls on both sides, 1000 beats
    for (int k = 0; k < 1000; k++) push((k / 4) % 4, 8'(k), (k % 4) == 3);
    req = 4'b1111;
    for (int c = 0; c < 20000; c++) begin
      if (exp_q.size() == 0) break;
      in_valid  = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 4; p++) out_ready[p] = ($urandom_range(0, 9) < 8);
      @(posedge clock); #1;
    end
    chk("t3_all_beats", 32'(exp_q.size()), 32'd0);
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    req       = 4'b0000;
    do_reset();

    // 4: request dropped mid-burst; burst still completes
    for (int k = 0; k < 4; k++) push(2, 8'(k), k == 3);
    for (int k = 4; k < 8; k++) push(3, 8'(k), k == 7);
    req      = 4'b1100;
    in_valid = 1'b1;
    wait_q(7, 50, cyc);
    req = 4'b1000;
    wait_q(3, 50, cyc);
    req = 4'b0000;
    wait_q(0, 50, cyc);
    @(negedge clock);
    chk("t4_idle_grant", 32'(grant), 32'h0);
    chk("t4_idle_in_ready", 32'(in_ready), 32'h0);
    @(negedge clock);
    chk("t4_idle_out_valid", 32'(out_valid), 32'h0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    do_reset();

    // 5: reset after the 2nd beat of a port-1 burst
    push(1, 8'h00, 1'b0);
    push(1, 8'h01, 1'b0);
    req      = 4'b0010;
    in_valid = 1'b1;
    wait_q(0, 50, cyc);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_rst_in_ready", 32'(in_ready), 32'h0);
    chk("t5_rst_out_valid", 32'(out_valid), 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t5_rst_grant", 32'(grant), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    req   = 4'b1111;
    for (int k = 0; k < 4; k++) push(0, 8'(k), k == 3);
    @(negedge clock);
    @(negedge clock);
    chk("t5_first_grant", 32'(grant), 32'h1);
    @(posedge clock); #1;
    wait_q(0, 50, cyc);
    in_valid = 1'b0;
    req      = 4'b0000;
    do_reset();

    // 6: single-beat bursts, grant alternates every beat
    req1      = 4'b0101;
    in_valid1 = 1'b1;
    @(negedge clock);
    chk("t6_grant_idle", 32'(grant1), 32'h0);
    for (int k = 0; k < 6; k++) begin
      logic [3:0] g;
      g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      @(negedge clock);
      chk("t6_grant", 32'(grant1), 32'(g));
      chk("t6_out_valid", 32'(out_valid1), 32'(g));
      chk("t6_in_ready", 32'(in_ready1), 32'h1);
      chk("t6_data", 32'(out_data1), 32'(k));
      chk("t6_burst_done", 32'(burst_done1), 32'(k > 0));
    end
    @(posedge clock); #1;
    in_valid1 = 1'b0;
    req1      = 4'b0000;
    repeat (2) @(posedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
